// File: rtl/c64_bus_pkg.sv
// c64_bus_pkg: C64 cycle phase constants and REU DMA slot state encoding.
package c64_bus_pkg;
    localparam int PHASE_LEN     = 32;
    localparam int DMA_WIN_START = 16;
    localparam int DMA_WIN_LEN   = 16;
    localparam int RAM_WIN_START = 4;
    localparam int RAM_WIN_LEN   = 4;
    localparam int BA_DELAY      = 3;
    localparam int PH_W          = $clog2(PHASE_LEN);
    localparam int CNT_W         = $clog2(BA_DELAY + 1);
    typedef enum logic [1:0] {IDLE, STALL, GRANT} dma_state_e;
endpackage

// File: rtl/reu_dma_slot_phase_window.sv
// phase_window: flags phases start..start+len-1 of a C64 cycle.
module phase_window
    import c64_bus_pkg::*;
(
    input  logic [PH_W-1:0] ph,
    input  logic [PH_W-1:0] start,
    input  logic [PH_W:0]   len,
    output logic            active
);
    assign active = ({1'b0, ph} >= {1'b0, start}) && ({1'b0, ph} < {1'b0, start} + len);
endmodule

// File: rtl/reu_dma_slot.sv
// reu_dma_slot: turns REU dma_req into a CPU stall plus per-cycle C64 bus and SDRAM grant windows.
module reu_dma_slot
    import c64_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cycle_sync,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_dout,
    input  logic        dma_we,
    output logic        dma_cycle,
    output logic [7:0]  dma_din,
    output logic        ram_cycle,
    input  logic        vic_ba,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_we,
    output logic        bus_oe,
    input  logic [7:0]  bus_din
);
    dma_state_e       state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d, ba_ok_q, ba_ok_d, cpu_rdy_q, cpu_rdy_d;
    logic             dma_cycle_q, dma_cycle_d, ram_cycle_q, ram_cycle_d;
    logic [7:0]       dma_din_q, dma_din_d;
    logic             dma_win, ram_win;

    phase_window u_dma_win (.ph(ph_d), .start(PH_W'(DMA_WIN_START)), .len((PH_W+1)'(DMA_WIN_LEN)), .active(dma_win));
    phase_window u_ram_win (.ph(ph_d), .start(PH_W'(RAM_WIN_START)), .len((PH_W+1)'(RAM_WIN_LEN)), .active(ram_win));

    always_comb begin
        ph_d        = cycle_sync ? '0 : (ph_q == PH_W'(PHASE_LEN - 1)) ? ph_q : ph_q + PH_W'(1);
        // sat marks a lost cycle_sync: the held last phase must not keep a window open
        sat_d       = cycle_sync ? 1'b0 : (sat_q || ph_q == PH_W'(PHASE_LEN - 1));
        ba_ok_d     = cycle_sync ? vic_ba : ba_ok_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        cpu_rdy_d   = cpu_rdy_q;
        case (state_q)
            IDLE: begin
                if (dma_req) begin
                    state_d   = STALL;
                    cnt_d     = CNT_W'(BA_DELAY);
                    cpu_rdy_d = 1'b0;
                end else if (cycle_sync) begin
                    cpu_rdy_d = 1'b1;
                end
            end
            STALL: begin
                if (!dma_req) begin
                    state_d   = IDLE;
                    cpu_rdy_d = 1'b1;
                end else if (cycle_sync) begin
                    if (cnt_q == '0) state_d = GRANT;
                    else cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GRANT: begin
                if (!dma_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        dma_cycle_d = (state_d == GRANT) && ba_ok_d && !sat_d && dma_win;
        ram_cycle_d = (state_d == GRANT) && !sat_d && ram_win;
        dma_din_d   = dma_cycle_q ? bus_din : dma_din_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ph_q        <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            ba_ok_q     <= 1'b0;
            cpu_rdy_q   <= 1'b1;
            dma_cycle_q <= 1'b0;
            ram_cycle_q <= 1'b0;
            dma_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            ba_ok_q     <= ba_ok_d;
            cpu_rdy_q   <= cpu_rdy_d;
            dma_cycle_q <= dma_cycle_d;
            ram_cycle_q <= ram_cycle_d;
            dma_din_q   <= dma_din_d;
        end
    end

    assign dma_cycle = dma_cycle_q;
    assign ram_cycle = ram_cycle_q;
    assign cpu_rdy   = cpu_rdy_q;
    assign dma_din   = dma_din_q;
    assign bus_oe    = dma_cycle_q;
    assign bus_we    = dma_we & dma_cycle_q;
    assign bus_addr  = dma_cycle_q ? dma_addr : 16'h0000;
    assign bus_dout  = dma_cycle_q ? dma_dout : 8'h00;
endmodule

// File: doc/reu_dma_slot.md
# reu_dma_slot

Bus-side responder for the REU DMA engine: converts the REU's `dma_req` into a CPU stall and a periodic grant window on the C64 bus (`dma_cycle`) plus a reserved SDRAM slot (`ram_cycle`). It drives the C64 address/data bus on the REU's behalf and returns read data. It sits between the REU and the C64 bus/SDRAM multiplexers and is timed by the system C64-cycle strobe.

## Interface
- `PHASE_LEN`, 32: clocks per C64 cycle.
- `DMA_WIN_START`, 16: first phase of the DMA window (phi2 half).
- `DMA_WIN_LEN`, 16: DMA window length in clocks; the REU needs 16.
- `RAM_WIN_START`, 4: first phase of the SDRAM slot.
- `RAM_WIN_LEN`, 4: SDRAM slot length in clocks; the REU needs 4.
- `BA_DELAY`, 3: full C64 cycles between stall request and first grant.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `cycle_sync` in 1: one-clock pulse marking phase 0 of each C64 cycle.
- `dma_req` in 1: DMA request from the REU.
- `dma_addr` in 16, `dma_dout` in 8, `dma_we` in 1: REU bus request.
- `dma_cycle` out 1: C64-bus grant window.
- `dma_din` out 8: read data returned to the REU.
- `ram_cycle` out 1: SDRAM slot grant.
- `vic_ba` in 1: 0 while the VIC-II claims the bus (badline/sprite).
- `cpu_rdy` out 1: 1 lets the 6510 run; 0 stalls it.
- `bus_addr` out 16, `bus_dout` out 8: C64 bus drive.
- `bus_we` out 1, `bus_oe` out 1: C64 bus write strobe and drive enable.
- `bus_din` in 8: C64 bus read data.

## Operation
- Phase counter `ph`:
  - Loads 0 on `cycle_sync`, otherwise increments and saturates at PHASE_LEN-1.
  - `cycle_sync` missing for more than PHASE_LEN clocks: `ph` holds and no new windows open.
- FSM states IDLE, STALL, GRANT.
- IDLE:
  - `cpu_rdy`=1.
  - On `dma_req`=1: `cpu_rdy`<=0, wait counter <= BA_DELAY, go to STALL.
- STALL:
  - Each `cycle_sync` decrements the wait counter.
  - At 0, go to GRANT at that same `cycle_sync`.
  - `dma_req` drops while in STALL: return to IDLE and set `cpu_rdy`<=1.
- GRANT:
  - `dma_cycle`=1 for phases DMA_WIN_START..DMA_WIN_START+DMA_WIN_LEN-1, but only when `vic_ba` was 1 at that cycle's `cycle_sync`.
  - Otherwise the window is skipped for the whole cycle. A window is never partial because `vic_ba` changes mid-window.
  - `ram_cycle`=1 for phases RAM_WIN_START..RAM_WIN_START+RAM_WIN_LEN-1 of every cycle in GRANT, regardless of `vic_ba`.
  - `dma_req` falls: close any open window (`dma_cycle`, `ram_cycle` <=0 next clock), go to IDLE, set `cpu_rdy`<=1 at the next `cycle_sync`.
- Bus drive while `dma_cycle`=1:
  - `bus_addr`=`dma_addr`.
  - `bus_dout`=`dma_dout`.
  - `bus_oe`=1.
  - `bus_we`=`dma_we & dma_cycle`, combinational, so a write never extends beyond the window.
- Outside the window: `bus_addr`=0, `bus_oe`=0, `bus_we`=0.
- `dma_din` <= `bus_din` every clock while `dma_cycle`=1; it holds otherwise.
- New `dma_req` while in IDLE and `cpu_rdy` still 0 (release pending): go to STALL again with the full BA_DELAY.

## Timing
- Reset values:
  - `cpu_rdy`=1.
  - `dma_cycle`, `ram_cycle`, `bus_we`, `bus_oe` = 0.
  - `bus_addr`=0, `bus_dout`=0, `dma_din`=0, `ph`=0.
  - FSM=IDLE.
- Reset mid-window drops all grants on the next clock.
- Latency from `dma_req` rising to the first `dma_cycle`: BA_DELAY full cycles, plus the remainder of the current cycle, plus DMA_WIN_START clocks. With defaults this is at most 4×32+16 clocks.
- `cpu_rdy` falls one clock after `dma_req` rises.
- Window edges are registered: `dma_cycle` rises on the clock where `ph` = DMA_WIN_START.
- At most one DMA window and one RAM slot per C64 cycle.

## Structure
- Shared package `c64_bus_pkg`:
  - Phase constants (PHASE_LEN, window starts and lengths, BA_DELAY).
  - FSM state enum.
- One sub-module, `phase_window`: a compare unit `(ph, start, len) -> active` used twice, once for DMA and once for RAM.

## Test plan
- **Basic grant:** `dma_req`=1 at phase 5, `vic_ba`=1.
  - `cpu_rdy`=0 next clock.
  - `dma_cycle` first rises at phase 16 of the 4th following cycle.
  - `dma_cycle` stays high exactly 16 clocks.
  - `ram_cycle` is high at phases 4..7 of every GRANT cycle.
- **Read:** `dma_addr`=$D000, `bus_din`=$5A during the window, `dma_we`=0.
  - `bus_addr`=$D000.
  - `bus_oe`=1, `bus_we`=0.
  - `dma_din`=$5A by window clock 15.
- **Write:** `dma_we`=1, `dma_dout`=$A5.
  - `bus_we` high exactly during the 16 window clocks, with `bus_dout`=$A5.
  - `bus_we`=0 on the clock after the window.
- **Badline:** `vic_ba`=0 at `cycle_sync` of a GRANT cycle.
  - No `dma_cycle` in that cycle, while `ram_cycle` still pulses.
  - Next cycle with `vic_ba`=1 grants normally.
- **Release:** drop `dma_req` at phase 20 inside a window.
  - `dma_cycle`=0 next clock.
  - `cpu_rdy`=1 at next `cycle_sync`.
  - Re-assert at the following phase 2: STALL again with a 3-cycle delay.
- **Reset:** assert `reset` at window clock 8.
  - All outputs at reset values next clock, FSM IDLE.
